// File: rtl/eeprom_master.sv
// eeprom_master: bus-mapped I2C initiator for the 2-wire serial EEPROM.
// The CPU loads DATA (0x2069) and writes CTRL (0x2068). The block then runs
// an optional START, an optional 8-bit write or read with acknowledge, and an
// optional STOP, and pulses irq_done when the command completes.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   bus_write        register write strobe; bus_read is not used
//   bus_address_in   register address
//   bus_data_in      register write data
//   bus_data_out     read data, zero unless the address is 0x2068/0x2069
//   scl, sda_out     serial clock and open-drain data drive (1 = released)
//   sda_in           serial data line as seen by the master
//   busy, irq_done   command in progress, one-cycle completion pulse
module eeprom_master #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        scl,
    output logic        sda_out,
    input  logic        sda_in,
    output logic        busy,
    output logic        irq_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [23:0] ADDR_CTRL = 24'h002068;
    localparam logic [23:0] ADDR_DATA = 24'h002069;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic wr;
        logic rd;
        logic ack_out;
    } cmd_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    cmd_t             cmd_q, cmd_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             irq_q, irq_d;
    logic [7:0]       tx_q, rx_q, rx_sh_q;
    logic             nack_q;

    logic quarter_end;
    logic phase_end;
    logic sample_pt;
    logic ctrl_wr;
    logic data_wr;

    logic unused_bus_read;
    assign unused_bus_read = bus_read;

    assign quarter_end = (div_q == DIV_LAST);
    assign phase_end   = quarter_end && (qtr_q == 2'd3);
    assign sample_pt   = quarter_end && (qtr_q == 2'd2);
    assign ctrl_wr     = bus_write && (bus_address_in == ADDR_CTRL) &&
                         (state_q == S_IDLE) && (bus_data_in[3:0] != 4'd0);
    assign data_wr     = bus_write && (bus_address_in == ADDR_DATA) &&
                         (state_q == S_IDLE);

    // State and line registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd7;
            cmd_q   <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            irq_q   <= irq_d;
        end
    end

    // Next state, counters, and the line levels the next state will drive.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        scl_d   = scl_q;
        sda_d   = sda_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr) begin
                    cmd_d.start   = bus_data_in[0];
                    cmd_d.stop    = bus_data_in[1];
                    cmd_d.wr      = bus_data_in[2];
                    cmd_d.rd      = bus_data_in[3] & ~bus_data_in[2];
                    cmd_d.ack_out = bus_data_in[4];
                    div_d = '0;
                    qtr_d = 2'd0;
                    bit_d = 3'd7;
                    if (bus_data_in[0])
                        state_d = S_START;
                    else if (bus_data_in[2] | bus_data_in[3])
                        state_d = S_BIT;
                    else
                        state_d = S_STOP;
                end
            end
            S_START, S_BIT, S_ACK, S_STOP: begin
                div_d = quarter_end ? '0 : div_q + DIV_W'(1);
                if (quarter_end)
                    qtr_d = qtr_q + 2'd1;
                if (phase_end) begin
                    case (state_q)
                        S_START: begin
                            bit_d = 3'd7;
                            if (cmd_q.wr | cmd_q.rd)
                                state_d = S_BIT;
                            else if (cmd_q.stop)
                                state_d = S_STOP;
                            else
                                state_d = S_DONE;
                        end
                        S_BIT: begin
                            if (bit_q == 3'd0)
                                state_d = S_ACK;
                            else
                                bit_d = bit_q - 3'd1;
                        end
                        S_ACK:   state_d = cmd_q.stop ? S_STOP : S_DONE;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Lines are a function of the upcoming phase/quarter; IDLE/DONE hold.
        case (state_d)
            S_START: begin
                case (qtr_d)
                    2'd0:    begin scl_d = scl_q; sda_d = 1'b1; end
                    2'd1:    begin scl_d = 1'b1;  sda_d = 1'b1; end
                    2'd2:    begin scl_d = 1'b1;  sda_d = 1'b0; end
                    default: begin scl_d = 1'b0;  sda_d = 1'b0; end
                endcase
            end
            S_BIT: begin
                scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_d = cmd_d.wr ? tx_q[bit_d] : 1'b1;
            end
            S_ACK: begin
                scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_d = cmd_d.wr ? 1'b1 : cmd_d.ack_out;
            end
            S_STOP: begin
                case (qtr_d)
                    2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
                    2'd1:    begin scl_d = 1'b1; sda_d = 1'b0; end
                    default: begin scl_d = 1'b1; sda_d = 1'b1; end
                endcase
            end
            default: begin
                scl_d = scl_q;
                sda_d = sda_q;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        irq_d  = (state_d == S_DONE);
    end

    // Data registers: tx load, read-bit shift, ack capture, rx commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            rx_sh_q <= 8'h00;
            nack_q  <= 1'b0;
        end else begin
            if (data_wr)
                tx_q <= bus_data_in;
            if ((state_q == S_BIT) && sample_pt && cmd_q.rd)
                rx_sh_q[bit_q] <= sda_in;
            if ((state_q == S_ACK) && sample_pt && cmd_q.wr)
                nack_q <= sda_in;
            if ((state_q == S_ACK) && phase_end && cmd_q.rd)
                rx_q <= rx_sh_q;
        end
    end

    // Register read mux contribution; zero outside this block's addresses.
    always_comb begin
        bus_data_out = 8'h00;
        if (bus_address_in == ADDR_CTRL)
            bus_data_out = {busy_q, nack_q, 6'b0};
        else if (bus_address_in == ADDR_DATA)
            bus_data_out = rx_q;
    end

    assign scl      = scl_q;
    assign sda_out  = sda_q;
    assign busy     = busy_q;
    assign irq_done = irq_q;

endmodule

// File: tb/tb_eeprom_master.sv
// Bench for eeprom_master with CLK_DIV=4 and a cycle-indexed EEPROM responder.
module tb_eeprom_master;

    localparam int unsigned D = 4;
    localparam logic [23:0] A_CTRL = 24'h002068;
    localparam logic [23:0] A_DATA = 24'h002069;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        scl;
    logic        sda_out;
    logic        sda_in;
    logic        busy;
    logic        irq_done;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: registers and the line levels left behind by a command.
    logic [7:0] m_tx, m_rx;
    logic       m_nack, m_scl, m_sda;

    eeprom_master #(.CLK_DIV(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .scl            (scl),
        .sda_out        (sda_out),
        .sda_in         (sda_in),
        .busy           (busy),
        .irq_done       (irq_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [7:0] d);
        bus_address_in = a;
        #1;
        d = bus_data_out;
    endtask

    task automatic wr_data(input logic [7:0] v);
        bus_write      = 1'b1;
        bus_address_in = A_DATA;
        bus_data_in    = v;
        tick();
        bus_write = 1'b0;
        m_tx      = v;
    endtask

    task automatic model_reset;
        m_tx = 8'h00; m_rx = 8'h00; m_nack = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    endtask

    // Issue one CTRL command, play the EEPROM side, and check the whole frame.
    // ic/id: cycle (1 = first busy cycle) for an extra CTRL/DATA write, 0 = none.
    task automatic run_cmd(input logic [7:0] ctrl, input logic [7:0] resp,
                           input logic ack_in, input int ic, input logic [7:0] icv,
                           input int id, input logic [7:0] idv, input string name);
        logic st, sp, wr, rd, ao, by, ackv, prev_scl, irq_at_fall, irq_extra, ack_bad, seq_bad;
        int off, len, ack_start, busy_len, fall_c, p, b;
        logic exp_q[$];
        logic obs_q[$];
        logic [7:0] rd_v;
        st = ctrl[0]; sp = ctrl[1]; wr = ctrl[2]; rd = ctrl[3] & ~ctrl[2]; ao = ctrl[4];
        by = wr | rd;
        ackv = wr ? 1'b1 : ao;
        off = st ? 4 * D : 0;
        len = (st ? 4 * D : 0) + (by ? 36 * D : 0) + (sp ? 4 * D : 0);
        ack_start = off + 32 * D;

        // SDA expected on each SCL rising edge of the frame.
        if (st && !m_scl) exp_q.push_back(1'b1);
        if (by) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(wr ? m_tx[i] : 1'b1);
            exp_q.push_back(ackv);
        end
        if (sp) exp_q.push_back(1'b0);

        prev_scl = scl;
        bus_write = 1'b1; bus_address_in = A_CTRL; bus_data_in = ctrl; sda_in = 1'b1;
        tick();
        bus_write = 1'b0;

        busy_len = 0; fall_c = 0; irq_at_fall = 1'b0; irq_extra = 1'b0; ack_bad = 1'b0;
        for (int c = 1; c <= len + 3; c++) begin
            p = c - 1;
            if (fall_c == 0) begin
                if (busy) busy_len++;
                else begin fall_c = c; irq_at_fall = irq_done; end
            end
            if (irq_done && c != fall_c) irq_extra = 1'b1;
            if (scl && !prev_scl) obs_q.push_back(sda_out);
            prev_scl = scl;
            if (by && p >= ack_start && p < ack_start + 4 * D && sda_out !== ackv) ack_bad = 1'b1;
            if (c == 2) begin
                bus_rd(A_CTRL, rd_v);
                n_total++;
                if (rd_v[7] !== 1'b1) $display("FAIL %s status_busy: got %b want 1", name, rd_v[7]);
                else n_pass++;
            end
            // EEPROM drives its bit for the byte slot this cycle falls in.
            sda_in = 1'b1;
            if (by && p >= off && p < off + 36 * D) begin
                b = (p - off) / (4 * D);
                sda_in = (b < 8) ? resp[7 - b] : ack_in;
            end
            if (c == ic) begin
                bus_write = 1'b1; bus_address_in = A_CTRL; bus_data_in = icv;
            end else if (c == id) begin
                bus_write = 1'b1; bus_address_in = A_DATA; bus_data_in = idv;
            end else bus_write = 1'b0;
            tick();
        end
        bus_write = 1'b0;
        sda_in    = 1'b1;

        if (wr) m_nack = ack_in;
        if (rd) m_rx = resp;
        if (sp) begin m_scl = 1'b1; m_sda = 1'b1; end
        else if (by) begin m_scl = 1'b0; m_sda = ackv; end
        else begin m_scl = 1'b0; m_sda = 1'b0; end

        n_total++;
        if (busy_len != len) $display("FAIL %s busy_len: got %0d want %0d", name, busy_len, len);
        else n_pass++;
        n_total++;
        if (fall_c == 0 || irq_at_fall !== 1'b1)
            $display("FAIL %s irq_at_done: got fall=%0d irq=%b want irq=1", name, fall_c, irq_at_fall);
        else n_pass++;
        n_total++;
        if (irq_extra !== 1'b0) $display("FAIL %s irq_width: got extra pulse want single", name);
        else n_pass++;
        seq_bad = (obs_q.size() != exp_q.size());
        if (!seq_bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) seq_bad = 1'b1;
        n_total++;
        if (seq_bad) $display("FAIL %s sda_on_scl_rise: got %p want %p", name, obs_q, exp_q);
        else n_pass++;
        if (by) begin
            n_total++;
            if (ack_bad) $display("FAIL %s ack_bit_sda: got deviation want %b all 4 quarters", name, ackv);
            else n_pass++;
        end
        n_total++;
        if (scl !== m_scl || sda_out !== m_sda)
            $display("FAIL %s final_lines: got scl=%b sda=%b want scl=%b sda=%b", name, scl, sda_out, m_scl, m_sda);
        else n_pass++;
        bus_rd(A_CTRL, rd_v);
        n_total++;
        if (rd_v !== {1'b0, m_nack, 6'b0}) $display("FAIL %s status: got %h want %h", name, rd_v, {1'b0, m_nack, 6'b0});
        else n_pass++;
        bus_rd(A_DATA, rd_v);
        n_total++;
        if (rd_v !== m_rx) $display("FAIL %s rx_data: got %h want %h", name, rd_v, m_rx);
        else n_pass++;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        model_reset();
        n_total++;
        if (scl !== 1'b1 || sda_out !== 1'b1) $display("FAIL reset_lines: got scl=%b sda=%b want 1 1", scl, sda_out);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || irq_done !== 1'b0) $display("FAIL reset_flags: got busy=%b irq=%b want 0 0", busy, irq_done);
        else n_pass++;
        bus_rd(A_CTRL, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL reset_status: got %h want 00", v);
        else n_pass++;
        bus_rd(A_DATA, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL reset_data: got %h want 00", v);
        else n_pass++;
        bus_rd(24'h002061, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL other_addr: got %h want 00", v);
        else n_pass++;
    endtask

    task automatic test_write_ack;
        wr_data(8'hA0);
        run_cmd(8'h07, 8'h00, 1'b0, 0, 8'h00, 0, 8'h00, "write_ack");
    endtask

    task automatic test_write_nack;
        run_cmd(8'h07, 8'h00, 1'b1, 0, 8'h00, 0, 8'h00, "write_nack");
    endtask

    task automatic test_read;
        run_cmd(8'h1A, 8'h5C, 1'b0, 0, 8'h00, 0, 8'h00, "read_nack");
    endtask

    task automatic test_busy_ignore;
        wr_data(8'hA0);
        run_cmd(8'h07, 8'h00, 1'b0, 30, 8'h01, 31, 8'hFF, "busy_ignore");
        run_cmd(8'h07, 8'h00, 1'b0, 0, 8'h00, 0, 8'h00, "tx_kept");
    endtask

    task automatic test_done_write;
        run_cmd(8'h07, 8'h00, 1'b0, 44 * D + 1, 8'h01, 0, 8'h00, "done_write");
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL done_write_ignored: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_noop;
        bus_write = 1'b1; bus_address_in = A_CTRL; bus_data_in = 8'h10;
        tick();
        bus_write = 1'b0;
        repeat (3) tick();
        n_total++;
        if (busy !== 1'b0 || irq_done !== 1'b0) $display("FAIL noop: got busy=%b irq=%b want 0 0", busy, irq_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        logic irq_seen;
        wr_data(8'h3C);
        bus_write = 1'b1; bus_address_in = A_CTRL; bus_data_in = 8'h05;
        tick();
        bus_write = 1'b0;
        irq_seen = 1'b0;
        for (int c = 1; c < 50; c++) begin
            if (irq_done) irq_seen = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_total++;
        if (scl !== 1'b1 || sda_out !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_mid_lines: got scl=%b sda=%b busy=%b want 1 1 0", scl, sda_out, busy);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (irq_done) irq_seen = 1'b1;
            tick();
        end
        n_total++;
        if (irq_seen !== 1'b0) $display("FAIL reset_mid_irq: got pulse want none");
        else n_pass++;
        bus_rd(A_CTRL, v);
        n_total++;
        if (v !== 8'h00) $display("FAIL reset_mid_status: got %h want 00", v);
        else n_pass++;
        run_cmd(8'h06, 8'h00, 1'b0, 0, 8'h00, 0, 8'h00, "after_reset_tx0");
    endtask

    task automatic test_random;
        logic [7:0] ctrl, resp;
        logic ack_in;
        for (int k = 0; k < 12; k++) begin
            ctrl = 8'($urandom);
            if (ctrl[3:0] == 4'd0) ctrl[0] = 1'b1;
            resp   = 8'($urandom);
            ack_in = 1'($urandom);
            wr_data(8'($urandom));
            run_cmd(ctrl, resp, ack_in, 0, 8'h00, 0, 8'h00, $sformatf("rand%0d_%h", k, ctrl));
        end
    endtask

    initial begin
        reset = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = A_CTRL; bus_data_in = 8'h00; sda_in = 1'b1;
        test_reset();
        test_write_ack();
        test_write_nack();
        test_read();
        test_busy_ignore();
        test_done_write();
        test_noop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
